// File: rtl/ysyx_23060184_csr_ctrl.sv
// CSR access and trap sequencer between execute and the CSR file.
// Reads the CSR, commits the write through a strobe, and returns old data or a PC redirect.
module ysyx_23060184_csr_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int CSR_AW = 10,
  parameter int unsigned ECALL_CAUSE = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_op,
  input  logic [11:0]           req_csr,
  input  logic [DATA_WIDTH-1:0] req_src,
  input  logic                  req_src_zero,
  input  logic [DATA_WIDTH-1:0] req_pc,
  output logic [CSR_AW-1:0]     csr_raddr,
  input  logic [DATA_WIDTH-1:0] csr_rdata,
  output logic [CSR_AW-1:0]     csr_waddr,
  output logic [DATA_WIDTH-1:0] csr_wdata,
  output logic                  csr_wen,
  output logic                  csr_ecall,
  output logic                  csr_mret,
  output logic [DATA_WIDTH-1:0] csr_pc,
  output logic                  csr_wvalid,
  input  logic                  csr_pready,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rd_data,
  output logic                  resp_redirect,
  output logic [DATA_WIDTH-1:0] resp_npc
);

  localparam logic [2:0] OP_RW    = 3'd0;
  localparam logic [2:0] OP_RS    = 3'd1;
  localparam logic [2:0] OP_RC    = 3'd2;
  localparam logic [2:0] OP_ECALL = 3'd3;
  localparam logic [2:0] OP_MRET  = 3'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e state, state_next;

  logic [2:0]            op_q;
  logic [CSR_AW-1:0]     addr_q;
  logic [DATA_WIDTH-1:0] src_q;
  logic                  src_zero_q;
  logic [DATA_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0] old_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] new_val;
  logic                  is_csr_op;
  logic                  is_ecall;
  logic                  is_mret;
  logic                  write_needed;
  logic                  unused_csr_hi;

  // Upper CSR address bits are decoded elsewhere; the file only sees the low bits.
  assign unused_csr_hi = ^req_csr[11:CSR_AW];

  assign is_csr_op = (op_q == OP_RW) || (op_q == OP_RS) || (op_q == OP_RC);
  assign is_ecall  = (op_q == OP_ECALL);
  assign is_mret   = (op_q == OP_MRET);
  assign write_needed = (op_q == OP_RW) || is_ecall ||
                        (((op_q == OP_RS) || (op_q == OP_RC)) && !src_zero_q);

  always_comb begin
    new_val = '0;
    case (op_q)
      OP_RW:   new_val = src_q;
      OP_RS:   new_val = csr_rdata | src_q;
      OP_RC:   new_val = csr_rdata & ~src_q;
      default: new_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q       <= '0;
      addr_q     <= '0;
      src_q      <= '0;
      src_zero_q <= 1'b0;
      pc_q       <= '0;
      old_q      <= '0;
      wdata_q    <= '0;
    end else begin
      if (state == IDLE && req_valid) begin
        op_q       <= req_op;
        addr_q     <= req_csr[CSR_AW-1:0];
        src_q      <= req_src;
        src_zero_q <= req_src_zero;
        pc_q       <= req_pc;
      end
      // For ECALL/MRET the read returns mtvec/mepc, which becomes the redirect target.
      if (state == READ) begin
        old_q   <= csr_rdata;
        wdata_q <= new_val;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (req_valid) state_next = READ;
      READ:  state_next = write_needed ? WRITE : RESP;
      WRITE: if (csr_pready) state_next = RESP;
      RESP:  if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready     = (state == IDLE);
    csr_raddr     = '0;
    csr_waddr     = '0;
    csr_wdata     = '0;
    csr_wen       = 1'b0;
    csr_ecall     = 1'b0;
    csr_mret      = 1'b0;
    csr_pc        = '0;
    csr_wvalid    = 1'b0;
    resp_valid    = 1'b0;
    resp_rd_data  = '0;
    resp_redirect = 1'b0;
    resp_npc      = '0;
    case (state)
      READ: begin
        csr_raddr = addr_q;
        csr_ecall = is_ecall;
        csr_mret  = is_mret;
      end
      // Write side is masked during reset so an abort never commits.
      WRITE: begin
        if (!rst) begin
          csr_wvalid = 1'b1;
          if (is_csr_op) begin
            csr_wen   = 1'b1;
            csr_waddr = addr_q;
            csr_wdata = wdata_q;
          end else if (is_ecall) begin
            csr_ecall = 1'b1;
            csr_wdata = DATA_WIDTH'(ECALL_CAUSE);
            csr_pc    = pc_q;
          end
        end
      end
      RESP: begin
        resp_valid    = 1'b1;
        resp_rd_data  = is_csr_op ? old_q : '0;
        resp_redirect = is_ecall || is_mret;
        resp_npc      = (is_ecall || is_mret) ? old_q : '0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ysyx_23060184_csr_ctrl.sv
// Self-checking bench: a behavioural CSR file plus a transaction-level reference model.
module tb_ysyx_23060184_csr_ctrl;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int unsigned CAUSE = 11;
  localparam logic [AW-1:0] MSTATUS  = 10'h300;
  localparam logic [AW-1:0] MTVEC    = 10'h305;
  localparam logic [AW-1:0] MSCRATCH = 10'h340;
  localparam logic [AW-1:0] MEPC     = 10'h341;
  localparam logic [AW-1:0] MCAUSE   = 10'h342;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [2:0]    req_op;
  logic [11:0]   req_csr;
  logic [DW-1:0] req_src;
  logic          req_src_zero;
  logic [DW-1:0] req_pc;
  logic [AW-1:0] csr_raddr;
  logic [DW-1:0] csr_rdata;
  logic [AW-1:0] csr_waddr;
  logic [DW-1:0] csr_wdata;
  logic          csr_wen;
  logic          csr_ecall;
  logic          csr_mret;
  logic [DW-1:0] csr_pc;
  logic          csr_wvalid;
  logic          csr_pready;
  logic          resp_valid;
  logic          resp_ready;
  logic [DW-1:0] resp_rd_data;
  logic          resp_redirect;
  logic [DW-1:0] resp_npc;

  int testsRun = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  ysyx_23060184_csr_ctrl #(.DATA_WIDTH(DW), .CSR_AW(AW), .ECALL_CAUSE(CAUSE)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_csr(req_csr),
    .req_src(req_src), .req_src_zero(req_src_zero), .req_pc(req_pc),
    .csr_raddr(csr_raddr), .csr_rdata(csr_rdata), .csr_waddr(csr_waddr),
    .csr_wdata(csr_wdata), .csr_wen(csr_wen), .csr_ecall(csr_ecall), .csr_mret(csr_mret),
    .csr_pc(csr_pc), .csr_wvalid(csr_wvalid), .csr_pready(csr_pready),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rd_data(resp_rd_data),
    .resp_redirect(resp_redirect), .resp_npc(resp_npc)
  );

  // Behavioural CSR file: combinational read, commit on strobe handshake.
  logic [DW-1:0] csrFile [1 << AW];
  logic [DW-1:0] refRegs [1 << AW];
  logic          preload;
  int            commits;

  function automatic logic [DW-1:0] initValue(int i);
    return (i == int'(MSTATUS)) ? 32'h0000_1800 : 32'h0;
  endfunction

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < (1 << AW); i++) csrFile[i] <= initValue(i);
      commits <= 0;
    end else if (csr_wvalid && csr_pready) begin
      commits <= commits + 1;
      if (csr_wen) csrFile[csr_waddr] <= csr_wdata;
      if (csr_ecall) begin
        csrFile[MCAUSE] <= csr_wdata;
        csrFile[MEPC]   <= csr_pc;
      end
    end
  end

  always_comb begin
    csr_rdata = '0;
    if (csr_ecall)     csr_rdata = csrFile[MTVEC];
    else if (csr_mret) csr_rdata = csrFile[MEPC];
    else               csr_rdata = csrFile[csr_raddr];
  end

  task automatic checkOutput(input string tag, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after the response handshake.
  task automatic applyStimulus(input logic [2:0] op, input logic [11:0] csrAddr,
                               input logic [DW-1:0] src, input logic srcZero,
                               input logic [DW-1:0] pc, input int pStall, input int rStall);
    logic [AW-1:0] a;
    logic [DW-1:0] old, newVal, expRd, expNpc, expWdata;
    logic          expWrite, expRedirect, isCsr;
    int            commitsBefore;
    a = csrAddr[AW-1:0];
    isCsr = (op <= 3'd2);
    old = '0; newVal = '0; expRd = '0; expNpc = '0; expWdata = '0;
    expWrite = 1'b0; expRedirect = 1'b0;
    case (op)
      3'd0: begin old = refRegs[a]; newVal = src;        expWrite = 1'b1;     end
      3'd1: begin old = refRegs[a]; newVal = old | src;  expWrite = !srcZero; end
      3'd2: begin old = refRegs[a]; newVal = old & ~src; expWrite = !srcZero; end
      3'd3: begin expNpc = refRegs[MTVEC]; expRedirect = 1'b1; expWrite = 1'b1; expWdata = CAUSE; end
      3'd4: begin expNpc = refRegs[MEPC];  expRedirect = 1'b1; end
      default: ;
    endcase
    if (isCsr) begin expRd = old; expWdata = newVal; end
    commitsBefore = commits;

    checkOutput("req_ready_idle", {31'd0, req_ready}, 1);
    req_valid = 1'b1; req_op = op; req_csr = csrAddr;
    req_src = src; req_src_zero = srcZero; req_pc = pc;
    @(negedge clk);
    req_valid = 1'($urandom_range(0, 1)); req_op = 3'($urandom);
    req_csr = 12'($urandom); req_src = $urandom; req_src_zero = 1'($urandom_range(0, 1));
    req_pc = $urandom;
    csr_pready = 1'($urandom_range(0, 1));
    checkOutput("read_req_ready", {31'd0, req_ready}, 0);
    checkOutput("read_ecall", {31'd0, csr_ecall}, {31'd0, op == 3'd3});
    checkOutput("read_mret", {31'd0, csr_mret}, {31'd0, op == 3'd4});
    checkOutput("read_wvalid", {31'd0, csr_wvalid}, 0);
    if (isCsr) checkOutput("read_raddr", {22'd0, csr_raddr}, {22'd0, a});

    if (expWrite) begin
      for (int k = 0; k <= pStall; k++) begin
        @(negedge clk);
        csr_pready = (k == pStall);
        checkOutput("write_wvalid", {31'd0, csr_wvalid}, 1);
        checkOutput("write_wen", {31'd0, csr_wen}, {31'd0, isCsr});
        checkOutput("write_ecall", {31'd0, csr_ecall}, {31'd0, op == 3'd3});
        checkOutput("write_wdata", csr_wdata, expWdata);
        if (isCsr) checkOutput("write_waddr", {22'd0, csr_waddr}, {22'd0, a});
        if (op == 3'd3) checkOutput("write_pc", csr_pc, pc);
        checkOutput("write_resp_valid", {31'd0, resp_valid}, 0);
        checkOutput("write_no_early_commit", commits, commitsBefore);
      end
    end

    for (int k = 0; k <= rStall; k++) begin
      @(negedge clk);
      csr_pready = 1'($urandom_range(0, 1));
      resp_ready = (k == rStall);
      checkOutput("resp_valid", {31'd0, resp_valid}, 1);
      checkOutput("resp_rd_data", resp_rd_data, expRd);
      checkOutput("resp_redirect", {31'd0, resp_redirect}, {31'd0, expRedirect});
      checkOutput("resp_npc", resp_npc, expNpc);
      checkOutput("resp_req_ready", {31'd0, req_ready}, 0);
      checkOutput("resp_wvalid", {31'd0, csr_wvalid}, 0);
      checkOutput("resp_csr_pc", csr_pc, 0);
    end

    @(negedge clk);
    resp_ready = 1'b0; req_valid = 1'b0;
    checkOutput("after_resp_valid", {31'd0, resp_valid}, 0);
    checkOutput("after_req_ready", {31'd0, req_ready}, 1);
    checkOutput("commit_count", commits, commitsBefore + (expWrite ? 1 : 0));

    if (isCsr && expWrite) refRegs[a] = newVal;
    if (op == 3'd3) begin
      refRegs[MCAUSE] = CAUSE;
      refRegs[MEPC]   = pc;
    end
    checkOutput("file_target", csrFile[a], refRegs[a]);
    checkOutput("file_mepc", csrFile[MEPC], refRegs[MEPC]);
    checkOutput("file_mcause", csrFile[MCAUSE], refRegs[MCAUSE]);
  endtask

  // Reset lands in WRITE while csr_pready is high; nothing may commit.
  task automatic resetInWrite();
    int commitsBefore;
    commitsBefore = commits;
    req_valid = 1'b1; req_op = 3'd0; req_csr = {2'b00, MSCRATCH};
    req_src = 32'hDEAD_BEEF; req_src_zero = 1'b0; req_pc = 32'h0;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    checkOutput("rst_pre_wvalid", {31'd0, csr_wvalid}, 1);
    csr_pready = 1'b1;
    rst = 1'b1;
    #1;
    checkOutput("rst_wvalid_masked", {31'd0, csr_wvalid}, 0);
    @(negedge clk);
    rst = 1'b0;
    csr_pready = 1'b0;
    checkOutput("rst_req_ready", {31'd0, req_ready}, 1);
    checkOutput("rst_wvalid", {31'd0, csr_wvalid}, 0);
    checkOutput("rst_wen", {31'd0, csr_wen}, 0);
    checkOutput("rst_wdata", csr_wdata, 0);
    checkOutput("rst_resp_valid", {31'd0, resp_valid}, 0);
    checkOutput("rst_raddr", {22'd0, csr_raddr}, 0);
    checkOutput("rst_no_commit", commits, commitsBefore);
    checkOutput("rst_file_unchanged", csrFile[MSCRATCH], refRegs[MSCRATCH]);
  endtask

  function automatic logic [11:0] pickCsr();
    case ($urandom_range(0, 4))
      0: return {2'b00, MSTATUS};
      1: return {2'b00, MTVEC};
      2: return {2'b00, MSCRATCH};
      3: return {2'b00, MEPC};
      default: return {2'b11, MCAUSE};
    endcase
  endfunction

  initial begin
    logic [2:0]    rOp;
    logic [DW-1:0] rSrc;
    logic          rZero;
    rst = 1'b1; preload = 1'b1;
    req_valid = 1'b0; req_op = '0; req_csr = '0; req_src = '0;
    req_src_zero = 1'b0; req_pc = '0; csr_pready = 1'b0; resp_ready = 1'b0;
    for (int i = 0; i < (1 << AW); i++) refRegs[i] = initValue(i);
    @(negedge clk);
    @(negedge clk);
    preload = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_req_ready", {31'd0, req_ready}, 1);
    checkOutput("reset_resp_valid", {31'd0, resp_valid}, 0);
    checkOutput("reset_wvalid", {31'd0, csr_wvalid}, 0);
    checkOutput("reset_ecall", {31'd0, csr_ecall}, 0);
    checkOutput("reset_rd_data", resp_rd_data, 0);
    checkOutput("reset_npc", resp_npc, 0);

    applyStimulus(3'd0, 12'h305, 32'h8000_0100, 1'b0, 32'h0, 0, 0);
    applyStimulus(3'd1, 12'h300, 32'h0000_0008, 1'b0, 32'h0, 0, 0);
    applyStimulus(3'd2, 12'h300, 32'h0,         1'b1, 32'h0, 0, 0);
    applyStimulus(3'd3, 12'h000, 32'h0,         1'b0, 32'h8000_0040, 0, 0);
    applyStimulus(3'd0, 12'h341, 32'h8000_0044, 1'b0, 32'h0, 0, 0);
    applyStimulus(3'd4, 12'h000, 32'h0,         1'b0, 32'h0, 0, 0);
    applyStimulus(3'd1, 12'h340, 32'h0000_00F0, 1'b0, 32'h0, 5, 3);
    applyStimulus(3'd3, 12'h000, 32'h0,         1'b0, 32'h8000_0200, 5, 3);
    applyStimulus(3'd6, 12'h305, 32'h1234_5678, 1'b0, 32'h0, 0, 2);

    resetInWrite();
    applyStimulus(3'd0, 12'h340, 32'hCAFE_0001, 1'b0, 32'h0, 0, 0);

    for (int n = 0; n < 60; n++) begin
      rOp   = 3'($urandom_range(0, 7));
      rZero = ($urandom_range(0, 3) == 0);
      rSrc  = rZero ? 32'h0 : $urandom;
      applyStimulus(rOp, pickCsr(), rSrc, rZero, {$urandom_range(0, 32'h3FFF_FFFF), 2'b00},
                    $urandom_range(0, 2), $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
